instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 25 ++
 rtl/instruction_fetch_unit_if.sv | 32 +++
 rtl/instruction_fetch_unit_fetch_skid_buffer.sv | 93 +++++++++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds datapath widths, the PC step and the fetch FSM state encoding.
//
// state        | meaning
// ST_FETCH     | request outstanding at PC; completions go to slot or skid
// ST_WAIT_SKID | skid full, no request issued until the slot drains
// ST_DISCARD   | abandoned request still held on the bus; its data is dropped
package instruction_fetch_unit_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int ADDR_WIDTH  = 32;
  localparam logic [ADDR_WIDTH-1:0] PC_INCREMENT = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'b00,
    ST_WAIT_SKID = 2'b01,
    ST_DISCARD   = 2'b10
  } fetch_state_t;

  // Redirect targets are forced to a word boundary.
  function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the decode stage.
//   IMEM_READ/IMEM_ADDRESS      : fetch request (held until IMEM_BUSYWAIT=0)
//   IMEM_READDATA/IMEM_BUSYWAIT : memory response
//   STALL                       : decode cannot accept the output slot
//   BRANCH_TAKEN/BRANCH_TARGET  : redirect request
//   OUT_INSTRUCTION/OUT_PC/OUT_VALID : output slot towards IF/ID
// master = fetch unit side, slave = memory/decode side.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic                   IMEM_READ;
  logic [ADDR_WIDTH-1:0]  IMEM_ADDRESS;
  logic [INSTR_WIDTH-1:0] IMEM_READDATA;
  logic                   IMEM_BUSYWAIT;
  logic                   STALL;
  logic                   BRANCH_TAKEN;
  logic [ADDR_WIDTH-1:0]  BRANCH_TARGET;
  logic [INSTR_WIDTH-1:0] OUT_INSTRUCTION;
  logic [ADDR_WIDTH-1:0]  OUT_PC;
  logic                   OUT_VALID;

  modport master (
    output IMEM_READ, IMEM_ADDRESS, OUT_INSTRUCTION, OUT_PC, OUT_VALID,
    input  IMEM_READDATA, IMEM_BUSYWAIT, STALL, BRANCH_TAKEN, BRANCH_TARGET
  );

  modport slave (
    input  IMEM_READ, IMEM_ADDRESS, OUT_INSTRUCTION, OUT_PC, OUT_VALID,
    output IMEM_READDATA, IMEM_BUSYWAIT, STALL, BRANCH_TAKEN, BRANCH_TARGET
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_skid_buffer.sv
// Output slot plus one-entry skid register for the fetch unit.
//   clk, rst_n      : clock, synchronous active-low reset
//   flush           : invalidate slot and skid (redirect)
//   wr_en/wr_*      : completed fetch to be stored
//   stall           : decode not accepting the slot
//   out_*           : output slot
//   skid_valid_nxt  : skid occupancy after this edge (used by the FSM)
module fetch_skid_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [INSTR_WIDTH-1:0] wr_instr,
  input  logic [ADDR_WIDTH-1:0]  wr_pc,
  input  logic                   stall,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic                   out_valid,
  output logic                   skid_valid_nxt
);

  logic [INSTR_WIDTH-1:0] slot_instr_q, slot_instr_d;
  logic [ADDR_WIDTH-1:0]  slot_pc_q, slot_pc_d;
  logic                   slot_valid_q, slot_valid_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_WIDTH-1:0]  skid_pc_q, skid_pc_d;
  logic                   skid_valid_q, skid_valid_d;
  logic                   slot_free;

  always_comb begin
    slot_instr_d = slot_instr_q;
    slot_pc_d    = slot_pc_q;
    slot_valid_d = slot_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    // Slot can take new content if empty or consumed at this edge.
    slot_free    = !slot_valid_q || !stall;

    if (flush) begin
      slot_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (slot_free) begin
      if (skid_valid_q) begin
        // Skid is older than any new completion, so it goes first.
        slot_instr_d = skid_instr_q;
        slot_pc_d    = skid_pc_q;
        slot_valid_d = 1'b1;
        skid_valid_d = wr_en;
        if (wr_en) begin
          skid_instr_d = wr_instr;
          skid_pc_d    = wr_pc;
        end
      end else if (wr_en) begin
        slot_instr_d = wr_instr;
        slot_pc_d    = wr_pc;
        slot_valid_d = 1'b1;
      end else begin
        slot_valid_d = 1'b0;
      end
    end else if (wr_en) begin
      skid_instr_d = wr_instr;
      skid_pc_d    = wr_pc;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_instr_q <= '0;
      slot_pc_q    <= '0;
      slot_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      slot_instr_q <= slot_instr_d;
      slot_pc_q    <= slot_pc_d;
      slot_valid_q <= slot_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_instr      = slot_instr_q;
  assign out_pc         = slot_pc_q;
  assign out_valid      = slot_valid_q;
  assign skid_valid_nxt = skid_valid_d;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, fetch FSM and memory request generation.
// The slot/skid pair lives in fetch_skid_buffer.
//   CLK   : clock, rising edge
//   RESET : synchronous active-low reset
//   bus   : memory request/response, decode handshake, redirect, output slot
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  instruction_fetch_unit_if.master bus
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  read_q, read_d;
  logic                  flush;
  logic                  wr_en;
  logic                  skid_valid_nxt;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    wr_en   = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (bus.BRANCH_TAKEN) begin
          pc_d    = align_word(bus.BRANCH_TARGET);
          flush   = 1'b1;
          // A still-busy request must be held on the bus until it finishes.
          state_d = bus.IMEM_BUSYWAIT ? ST_DISCARD : ST_FETCH;
        end else if (!bus.IMEM_BUSYWAIT) begin
          wr_en   = 1'b1;
          pc_d    = pc_q + PC_INCREMENT;
          state_d = skid_valid_nxt ? ST_WAIT_SKID : ST_FETCH;
        end
      end
      ST_WAIT_SKID: begin
        if (bus.BRANCH_TAKEN) begin
          pc_d    = align_word(bus.BRANCH_TARGET);
          flush   = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = skid_valid_nxt ? ST_WAIT_SKID : ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (bus.BRANCH_TAKEN) begin
          pc_d  = align_word(bus.BRANCH_TARGET);
          flush = 1'b1;
        end
        if (!bus.IMEM_BUSYWAIT) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    read_d = (state_d != ST_WAIT_SKID);
    // DISCARD keeps presenting the abandoned address until it completes.
    addr_d = (state_d == ST_DISCARD) ? addr_q : pc_d;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      read_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
    end
  end

  // read_q is primed during reset so the first request appears in the first
  // cycle after release; gating keeps the bus idle while reset is held.
  assign bus.IMEM_READ    = read_q & RESET;
  assign bus.IMEM_ADDRESS = addr_q;

  fetch_skid_buffer u_skid (
    .clk            (CLK),
    .rst_n          (RESET),
    .flush          (flush),
    .wr_en          (wr_en),
    .wr_instr       (bus.IMEM_READDATA),
    .wr_pc          (pc_q),
    .stall          (bus.STALL),
    .out_instr      (bus.OUT_INSTRUCTION),
    .out_pc         (bus.OUT_PC),
    .out_valid      (bus.OUT_VALID),
    .skid_valid_nxt (skid_valid_nxt)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic CLK;
  logic RESET;
  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory model: instruction word is the bitwise inverse of its address.
  always_comb bus.IMEM_READDATA = ~bus.IMEM_ADDRESS;

  typedef struct {
    logic        stall;
    logic        busy;
    logic        br;
    logic [31:0] tgt;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(logic s, logic b, logic br, logic [31:0] t,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ep);
    vec_t v;
    v.stall = s; v.busy = b; v.br = br; v.tgt = t;
    v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic s, input logic b, input logic br, input logic [31:0] t);
    bus.STALL         = s;
    bus.IMEM_BUSYWAIT = b;
    bus.BRANCH_TAKEN  = br;
    bus.BRANCH_TARGET = t;
  endtask

  initial begin
    int consumed;
    logic [31:0] exp_next;
    logic seen;

    //              stall busy br  target        read addr          valid pc
    vecs[0]  = mk(0, 0, 0, 32'h0,           1, 32'h4,         1, 32'h0);
    vecs[1]  = mk(0, 0, 0, 32'h0,           1, 32'h8,         1, 32'h4);
    vecs[2]  = mk(0, 1, 0, 32'h0,           1, 32'h8,         0, 32'h0);
    vecs[3]  = mk(0, 1, 0, 32'h0,           1, 32'h8,         0, 32'h0);
    vecs[4]  = mk(0, 1, 0, 32'h0,           1, 32'h8,         0, 32'h0);
    vecs[5]  = mk(0, 0, 0, 32'h0,           1, 32'hC,         1, 32'h8);
    vecs[6]  = mk(0, 0, 0, 32'h0,           1, 32'h10,        1, 32'hC);
    vecs[7]  = mk(1, 0, 0, 32'h0,           0, 32'h0,         1, 32'hC);
    vecs[8]  = mk(1, 0, 0, 32'h0,           0, 32'h0,         1, 32'hC);
    vecs[9]  = mk(1, 0, 0, 32'h0,           0, 32'h0,         1, 32'hC);
    vecs[10] = mk(1, 0, 0, 32'h0,           0, 32'h0,         1, 32'hC);
    vecs[11] = mk(0, 0, 0, 32'h0,           1, 32'h14,        1, 32'h10);
    vecs[12] = mk(0, 0, 0, 32'h0,           1, 32'h18,        1, 32'h14);
    vecs[13] = mk(0, 1, 1, 32'h103,         1, 32'h18,        0, 32'h0);
    vecs[14] = mk(0, 1, 0, 32'h0,           1, 32'h18,        0, 32'h0);
    vecs[15] = mk(0, 0, 0, 32'h0,           1, 32'h100,       0, 32'h0);
    vecs[16] = mk(0, 0, 0, 32'h0,           1, 32'h104,       1, 32'h100);
    vecs[17] = mk(0, 0, 1, 32'h200,         1, 32'h200,       0, 32'h0);
    vecs[18] = mk(0, 0, 0, 32'h0,           1, 32'h204,       1, 32'h200);
    vecs[19] = mk(1, 0, 0, 32'h0,           0, 32'h0,         1, 32'h200);
    vecs[20] = mk(1, 0, 1, 32'h300,         1, 32'h300,       0, 32'h0);
    vecs[21] = mk(1, 0, 0, 32'h0,           1, 32'h304,       1, 32'h300);
    vecs[22] = mk(0, 1, 1, 32'h400,         1, 32'h304,       0, 32'h0);
    vecs[23] = mk(0, 1, 1, 32'h500,         1, 32'h304,       0, 32'h0);
    vecs[24] = mk(0, 0, 0, 32'h0,           1, 32'h500,       0, 32'h0);
    vecs[25] = mk(0, 0, 1, 32'hFFFF_FFFE,   1, 32'hFFFF_FFFC, 0, 32'h0);
    vecs[26] = mk(0, 0, 0, 32'h0,           1, 32'h0,         1, 32'hFFFF_FFFC);
    vecs[27] = mk(0, 0, 0, 32'h0,           1, 32'h4,         1, 32'h0);

    // Reset behaviour
    RESET = 1'b0;
    drive(0, 0, 0, 32'h0);
    #1;
    chk("rst_read_during", 32'(bus.IMEM_READ), 32'h0);
    tick();
    tick();
    chk("rst_read", 32'(bus.IMEM_READ), 32'h0);
    chk("rst_valid", 32'(bus.OUT_VALID), 32'h0);
    chk("rst_pc", bus.OUT_PC, 32'h0);
    chk("rst_instr", bus.OUT_INSTRUCTION, 32'h0);
    RESET = 1'b1;
    #1;
    chk("rel_read", 32'(bus.IMEM_READ), 32'h1);
    chk("rel_addr", bus.IMEM_ADDRESS, 32'h0);

    // Directed table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].busy, vecs[i].br, vecs[i].tgt);
      tick();
      chk($sformatf("v%0d_read", i), 32'(bus.IMEM_READ), 32'(vecs[i].e_read));
      if (vecs[i].e_read)
        chk($sformatf("v%0d_addr", i), bus.IMEM_ADDRESS, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), 32'(bus.OUT_VALID), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), bus.OUT_PC, vecs[i].e_pc);
        chk($sformatf("v%0d_instr", i), bus.OUT_INSTRUCTION, ~vecs[i].e_pc);
      end
    end

    // Reset while a request is outstanding
    drive(0, 1, 0, 32'h0);
    tick();
    chk("mid_read_busy", 32'(bus.IMEM_READ), 32'h1);
    RESET = 1'b0;
    #1;
    chk("mid_read_in_rst", 32'(bus.IMEM_READ), 32'h0);
    tick();
    chk("mid_valid", 32'(bus.OUT_VALID), 32'h0);
    chk("mid_read", 32'(bus.IMEM_READ), 32'h0);
    chk("mid_outpc", bus.OUT_PC, 32'h0);
    RESET = 1'b1;
    drive(0, 0, 0, 32'h0);
    #1;
    chk("mid_refetch_read", 32'(bus.IMEM_READ), 32'h1);
    chk("mid_refetch_addr", bus.IMEM_ADDRESS, 32'h0);
    tick();
    chk("mid_refetch_valid", 32'(bus.OUT_VALID), 32'h1);
    chk("mid_refetch_pc", bus.OUT_PC, 32'h0);

    // Random stall/busy stream: consumed PCs must be consecutive.
    exp_next = 32'h0;
    consumed = 0;
    for (int c = 0; c < 80; c++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 0, 32'h0);
      #1;
      if (bus.OUT_VALID && !bus.STALL) begin
        chk("stream_pc", bus.OUT_PC, exp_next);
        chk("stream_instr", bus.OUT_INSTRUCTION, ~exp_next);
        exp_next = exp_next + 32'h4;
        consumed++;
      end
      tick();
    end
    chk("stream_progress", 32'(consumed > 10), 32'h1);

    // Redirect then bounded wait for the target to appear.
    drive(0, 0, 1, 32'h801);
    tick();
    chk("redir_valid", 32'(bus.OUT_VALID), 32'h0);
    drive(0, 0, 0, 32'h0);
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      tick();
      if (bus.OUT_VALID) seen = 1'b1;
    end
    chk("redir_wait", 32'(seen), 32'h1);
    chk("redir_pc", bus.OUT_PC, 32'h800);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
